// File: rtl/gemm_operand_loader_pkg.sv
// gemm_pkg: shared types and job geometry for the GEMM operand loader and result streamer.
package gemm_pkg;
   localparam int MATRIX_DIM    = 4;
   localparam int ELEMS_PER_MAT = MATRIX_DIM * MATRIX_DIM;
   localparam int BEATS_PER_JOB = 2 + 3 * ELEMS_PER_MAT;
   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} gemm_state_t;
   typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C} mat_sel_t;
   function automatic int beats_per_job(input int h, input int w);
      return 2 + 3 * h * w;
   endfunction
endpackage

// File: rtl/gemm_operand_loader_if.sv
// gemm_operand_loader_if: element stream in, operand arrays and core handshake out.
interface gemm_operand_loader_if #(
   parameter int DATA_WIDTH    = 64,
   parameter int MATRIX_HEIGHT = 4,
   parameter int MATRIX_WIDTH  = 4
);
   logic ivalid, oready, ilast, igemm_done, ostart, obusy, oerr;
   logic signed [DATA_WIDTH-1:0] idata;
   logic [DATA_WIDTH-1:0] oalpha, obeta;
   logic signed [DATA_WIDTH-1:0] oa_matrix [MATRIX_HEIGHT][MATRIX_WIDTH];
   logic signed [DATA_WIDTH-1:0] ob_matrix [MATRIX_HEIGHT][MATRIX_WIDTH];
   logic signed [DATA_WIDTH-1:0] oc_matrix [MATRIX_HEIGHT][MATRIX_WIDTH];
   modport master (
      output ivalid, idata, ilast, igemm_done,
      input  oready, oalpha, obeta, oa_matrix, ob_matrix, oc_matrix, ostart, obusy, oerr
   );
   modport slave (
      input  ivalid, idata, ilast, igemm_done,
      output oready, oalpha, obeta, oa_matrix, ob_matrix, oc_matrix, ostart, obusy, oerr
   );
endinterface

// File: rtl/gemm_operand_loader_decoder.sv
// gemm_beat_decoder: maps a job beat index onto its scalar or matrix slot.
module gemm_beat_decoder
   import gemm_pkg::*;
#(
   parameter int MATRIX_HEIGHT = 4,
   parameter int MATRIX_WIDTH  = 4,
   parameter int CW = 6,
   parameter int RW = 2,
   parameter int KW = 2
) (
   input  logic [CW-1:0] cnt,
   output logic          is_alpha,
   output logic          is_beta,
   output mat_sel_t      mat_sel,
   output logic [RW-1:0] row,
   output logic [KW-1:0] col
);
   localparam logic [CW-1:0] EC = CW'(MATRIX_HEIGHT * MATRIX_WIDTH);
   localparam logic [CW-1:0] WC = CW'(MATRIX_WIDTH);
   logic [CW-1:0] idx, rem, m;
   always_comb begin
      idx      = cnt - CW'(2);
      rem      = idx % EC;
      m        = idx / EC;
      is_alpha = cnt == '0;
      is_beta  = cnt == CW'(1);
      mat_sel  = m == '0 ? SEL_A : m == CW'(1) ? SEL_B : SEL_C;
      row      = RW'(rem / WC);
      col      = KW'(rem % WC);
   end
endmodule

// File: rtl/gemm_operand_loader.sv
// gemm_operand_loader: assembles alpha, beta, A, B, C from one element stream and
// hands them to the GEMM core with a start pulse, holding them until done.
module gemm_operand_loader
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int MATRIX_HEIGHT = 4,
   parameter int MATRIX_WIDTH  = 4
) (
   input logic iclk,
   input logic irst,
   gemm_operand_loader_if.slave bus
);
   localparam int N  = beats_per_job(MATRIX_HEIGHT, MATRIX_WIDTH);
   localparam int CW = $clog2(N);
   localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
   localparam int KW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_LOAD  = LOAD;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_WAIT  = WAIT;

   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic err, ready, acc, last_beat, is_alpha, is_beta;
   mat_sel_t sel;
   logic [RW-1:0] row;
   logic [KW-1:0] col;
   logic [DATA_WIDTH-1:0] alpha, beta;
   logic signed [DATA_WIDTH-1:0] a_q [MATRIX_HEIGHT][MATRIX_WIDTH];
   logic signed [DATA_WIDTH-1:0] b_q [MATRIX_HEIGHT][MATRIX_WIDTH];
   logic signed [DATA_WIDTH-1:0] c_q [MATRIX_HEIGHT][MATRIX_WIDTH];

   gemm_beat_decoder #(
      .MATRIX_HEIGHT(MATRIX_HEIGHT), .MATRIX_WIDTH(MATRIX_WIDTH), .CW(CW), .RW(RW), .KW(KW)
   ) dec (
      .cnt(cnt), .is_alpha(is_alpha), .is_beta(is_beta), .mat_sel(sel), .row(row), .col(col)
   );

   assign ready        = state == S_IDLE || state == S_LOAD;
   assign acc          = bus.ivalid && ready;
   assign last_beat    = cnt == CW'(N - 1);
   assign bus.oready   = ready;
   assign bus.ostart   = state == S_START;
   assign bus.obusy    = state != S_IDLE;
   assign bus.oerr     = err;
   assign bus.oalpha   = alpha;
   assign bus.obeta    = beta;
   assign bus.oa_matrix = a_q;
   assign bus.ob_matrix = b_q;
   assign bus.oc_matrix = c_q;

   // ilast must coincide exactly with the final beat; any disagreement drops the job
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state <= S_IDLE;
         cnt   <= '0;
         err   <= 1'b0;
         alpha <= '0;
         beta  <= '0;
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         c_q   <= '{default: '0};
      end else begin
         err <= 1'b0;
         if (acc) begin
            if (bus.ilast != last_beat) begin
               err   <= 1'b1;
               cnt   <= '0;
               state <= S_IDLE;
            end else begin
               if (is_alpha) alpha <= bus.idata;
               else if (is_beta) beta <= bus.idata;
               else if (sel == SEL_A) a_q[row][col] <= bus.idata;
               else if (sel == SEL_B) b_q[row][col] <= bus.idata;
               else c_q[row][col] <= bus.idata;
               cnt   <= last_beat ? '0 : cnt + 1'b1;
               state <= last_beat ? S_START : S_LOAD;
            end
         end else if (state == S_START) begin
            state <= S_WAIT;
         end else if (state == S_WAIT && bus.igemm_done) begin
            state <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_gemm_operand_loader.sv
// tb_gemm_operand_loader: vector-table jobs with a start-pulse scoreboard plus reset corner cases.
module tb_gemm_operand_loader;
   localparam int DW = 64;
   localparam int H  = 4;
   localparam int W  = 4;
   localparam int N  = 2 + 3 * H * W;

   typedef struct {
      string  name;
      longint base;
      int     n;
      int     last_pos;
      int     gap;
      bit     ok;
      int     hold;
   } vec_t;

   logic iclk = 1'b0;
   logic irst;
   int checks = 0, failures = 0, starts = 0, errs = 0, nstart = 0, nerr = 0;
   longint sb[$];
   vec_t vt[7];

   gemm_operand_loader_if #(.DATA_WIDTH(DW), .MATRIX_HEIGHT(H), .MATRIX_WIDTH(W)) bus();
   gemm_operand_loader #(.DATA_WIDTH(DW), .MATRIX_HEIGHT(H), .MATRIX_WIDTH(W)) dut (
      .iclk(iclk), .irst(irst), .bus(bus)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ev(input longint base, input int k);
      return 64'(base + longint'(k) + 1);
   endfunction

   function automatic logic [63:0] elem(input int m, input int r, input int c);
      return m == 0 ? bus.oa_matrix[r][c] : m == 1 ? bus.ob_matrix[r][c] : bus.oc_matrix[r][c];
   endfunction

   task automatic cmp_job(input string tag, input longint base);
      chk({tag, "_alpha"}, bus.oalpha, ev(base, 0));
      chk({tag, "_beta"}, bus.obeta, ev(base, 1));
      for (int m = 0; m < 3; m++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               chk($sformatf("%s_m%0d_%0d_%0d", tag, m, r, c), elem(m, r, c), ev(base, 2 + m * H * W + r * W + c));
   endtask

   task automatic cmp_zero(input string tag);
      chk({tag, "_alpha"}, bus.oalpha, 64'd0);
      chk({tag, "_beta"}, bus.obeta, 64'd0);
      for (int m = 0; m < 3; m++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               chk($sformatf("%s_m%0d_%0d_%0d", tag, m, r, c), elem(m, r, c), 64'd0);
   endtask

   task automatic beat(input logic [63:0] d, input logic l);
      chk("ready_beat", {63'd0, bus.oready}, 64'd1);
      bus.ivalid = 1'b1;
      bus.idata  = d;
      bus.ilast  = l;
      @(posedge iclk);
      #1;
      bus.ivalid = 1'b0;
      bus.ilast  = 1'b0;
   endtask

   task automatic drive(input longint base, input int n, input int last_pos, input int gap, input bit push);
      for (int k = 0; k < n; k++) begin
         if (k > 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))) begin
            @(posedge iclk);
            #1;
         end
         if (push && k == n - 1) sb.push_back(base);
         beat(ev(base, k), k == last_pos);
      end
   endtask

   task automatic finish_start(input string name, input longint base, input int hold);
      nstart++;
      chk({name, "_start"}, {63'd0, bus.ostart}, 64'd1);
      chk({name, "_ready_low"}, {63'd0, bus.oready}, 64'd0);
      chk({name, "_busy"}, {63'd0, bus.obusy}, 64'd1);
      chk({name, "_no_err"}, {63'd0, bus.oerr}, 64'd0);
      bus.ivalid = 1'b1;
      bus.idata  = 64'h0bad_f00d_dead_beef;
      bus.ilast  = 1'b1;
      @(posedge iclk);
      #1;
      chk({name, "_start_once"}, {63'd0, bus.ostart}, 64'd0);
      repeat (hold) @(posedge iclk);
      #1;
      chk({name, "_ready_held"}, {63'd0, bus.oready}, 64'd0);
      bus.ivalid = 1'b0;
      bus.ilast  = 1'b0;
      cmp_job({name, "_hold"}, base);
      bus.igemm_done = 1'b1;
      @(posedge iclk);
      #1;
      bus.igemm_done = 1'b0;
      chk({name, "_busy_fall"}, {63'd0, bus.obusy}, 64'd0);
      chk({name, "_ready_back"}, {63'd0, bus.oready}, 64'd1);
   endtask

   always @(negedge iclk) begin
      if (bus.oerr) errs++;
      if (bus.ostart) begin
         starts++;
         chk("start_expected", {63'd0, sb.size() != 0}, 64'd1);
         if (sb.size() != 0) cmp_job("start", sb.pop_front());
      end
   end

   initial begin
      vt[0] = '{"basic",      0,                  N,  N - 1, 0, 1'b1, 100};
      vt[1] = '{"toggle",     0,                  N,  N - 1, 1, 1'b1, 0};
      vt[2] = '{"last20",     500,                20, 19,    0, 1'b0, 0};
      vt[3] = '{"after_err",  -1000,              N,  N - 1, 0, 1'b1, 0};
      vt[4] = '{"no_last",    7,                  N,  -1,    0, 1'b0, 0};
      vt[5] = '{"single",     9,                  1,  0,     0, 1'b0, 0};
      vt[6] = '{"random_gap", 64'sd1000000000000, N,  N - 1, 2, 1'b1, 3};
      irst = 1'b1;
      bus.ivalid = 1'b0;
      bus.idata = '0;
      bus.ilast = 1'b0;
      bus.igemm_done = 1'b0;
      repeat (2) @(posedge iclk);
      #1;
      chk("rst_ready", {63'd0, bus.oready}, 64'd1);
      chk("rst_start", {63'd0, bus.ostart}, 64'd0);
      chk("rst_busy", {63'd0, bus.obusy}, 64'd0);
      chk("rst_err", {63'd0, bus.oerr}, 64'd0);
      cmp_zero("rst");
      irst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive(vt[i].base, vt[i].n, vt[i].last_pos, vt[i].gap, vt[i].ok);
         if (vt[i].ok) finish_start(vt[i].name, vt[i].base, vt[i].hold);
         else begin
            nerr++;
            chk({vt[i].name, "_err"}, {63'd0, bus.oerr}, 64'd1);
            chk({vt[i].name, "_no_start"}, {63'd0, bus.ostart}, 64'd0);
            chk({vt[i].name, "_idle"}, {63'd0, bus.obusy}, 64'd0);
            chk({vt[i].name, "_ready"}, {63'd0, bus.oready}, 64'd1);
            @(posedge iclk);
            #1;
            chk({vt[i].name, "_err_once"}, {63'd0, bus.oerr}, 64'd0);
         end
      end
      bus.igemm_done = 1'b1;
      @(posedge iclk);
      #1;
      bus.igemm_done = 1'b0;
      chk("done_idle_ignored", {63'd0, bus.obusy}, 64'd0);
      drive(300, 30, -1, 0, 1'b0);
      chk("mid_busy", {63'd0, bus.obusy}, 64'd1);
      irst = 1'b1;
      #2;
      chk("midrst_ready", {63'd0, bus.oready}, 64'd1);
      chk("midrst_busy", {63'd0, bus.obusy}, 64'd0);
      chk("midrst_cnt", 64'(dut.cnt), 64'd0);
      cmp_zero("midrst");
      @(posedge iclk);
      #1;
      irst = 1'b0;
      drive(4000, N, N - 1, 0, 1'b1);
      finish_start("post_rst", 4000, 2);
      repeat (2) @(posedge iclk);
      #1;
      chk("start_count", 64'(starts), 64'(nstart));
      chk("err_count", 64'(errs), 64'(nerr));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gemm_operand_loader.md
# gemm_operand_loader

Upstream feeder for the GEMM core. Accepts a single valid/ready element stream carrying alpha, beta and the A, B and C operand matrices, and assembles them into register arrays. After the last element it pulses `ostart` to the core and holds every operand stable until the core reports done. It is then ready for the next job.

## Interface
Parameters:
- `DATA_WIDTH`, 64, element and scalar width
- `MATRIX_HEIGHT`, 4, rows of every matrix
- `MATRIX_WIDTH`, 4, columns of every matrix; `MATRIX_HEIGHT == MATRIX_WIDTH` is required

Ports:
- `iclk`  in  1  clock; single clock domain
- `irst`  in  1  reset, asynchronous, active-high
- `ivalid`  in  1  stream element valid
- `oready`  out  1  loader can accept an element
- `idata`  in  DATA_WIDTH  stream element, signed two's complement
- `ilast`  in  1  marks the final element of a job
- `igemm_done`  in  1  one-cycle done pulse from the GEMM core
- `oalpha`, `obeta`  out  DATA_WIDTH each  latched scalars
- `oa_matrix`, `ob_matrix`, `oc_matrix`  out  signed DATA_WIDTH × [MATRIX_HEIGHT][MATRIX_WIDTH]  operand arrays
- `ostart`  out  1  one-cycle start pulse to the core
- `obusy`  out  1  high whenever state ≠ IDLE
- `oerr`  out  1  one-cycle framing-error pulse

## Operation
- A beat is accepted when `ivalid && oready`. No other condition accepts a beat.
- Job length is N = 2 + 3·H·W beats (50 at defaults), in this order:
  - beat 0: alpha
  - beat 1: beta
  - beats 2..: A, row-major
  - then B, row-major
  - then C, row-major
- Beat counter `cnt` runs 0..N-1. Decode: `m = (cnt-2)/(H·W)` selects A/B/C, `r = ((cnt-2)%(H·W))/W`, `c = (cnt-2)%W`.
- States:
  - IDLE: `oready` = 1. An accepted beat stores alpha, sets `cnt` = 1 and moves to LOAD.
  - LOAD: `oready` = 1. Each accepted beat is written to its decoded slot and `cnt` increments.
  - START: `oready` = 0, `ostart` = 1 for exactly this one cycle, then go to WAIT.
  - WAIT: `oready` = 0. `igemm_done` moves the FSM to IDLE.
- Framing rules:
  - An accepted beat with `cnt == N-1` and `ilast == 1` moves the FSM to START.
  - `ilast == 1` on any earlier beat is an error.
  - `ilast == 0` on beat N-1 is also an error.
  - On error: `oerr` pulses one cycle, the beat is discarded, `cnt` clears, the FSM goes to IDLE and `ostart` is never raised. Matrix contents are then undefined for use.
- A single-beat job with `ilast` set in IDLE is an error: `oerr` pulses and the FSM stays in IDLE.
- `igemm_done` outside WAIT is ignored.
- Operand and scalar registers change only on accepted beats. They stay stable from START until the FSM leaves WAIT.
- No arithmetic is performed. Elements are stored bit-exact.

## Timing
- Reset values: all matrices, `oalpha` and `obeta` are 0; `cnt` = 0; state = IDLE; `oready` = 1; `ostart`, `obusy` and `oerr` are 0.
- Reset asserted at any point (mid-LOAD, WAIT) returns immediately to reset values. Any in-flight job is dropped.
- The first start pulse can occur no earlier than N+1 cycles after reset release.
- `ostart` is high in the cycle after the final beat is accepted (registered).
- `oerr` is high in the cycle after the offending beat is accepted.
- `oready` is a registered function of state only and does not depend on `ivalid`.
- `obusy` goes high in the cycle after beat 0 is accepted and falls in the cycle after `igemm_done` is seen in WAIT.
- A new job's beat 0 can be accepted in the cycle after the return to IDLE. Minimum job period is N + 2 + core latency cycles.
- `ivalid` may drop between beats without penalty. Stalls do not alter `cnt`.

## Structure
- Package `gemm_pkg`:
  - `gemm_state_t` enum (IDLE, LOAD, START, WAIT)
  - localparam `BEATS_PER_JOB`
  - localparam `ELEMS_PER_MAT`
  - `mat_sel_t` enum (SEL_A, SEL_B, SEL_C)
- Sub-module `gemm_beat_decoder`: combinational `cnt` → {is_alpha, is_beta, mat_sel, row, col}. It is shared with the downstream result streamer.
- The loader itself holds the FSM, the counter, the framing check and the register arrays.

## Test plan
- Reset, then 50 beats with values 1..50 and `ilast` on beat 50 → `oalpha` = 1, `obeta` = 2, `oa_matrix[0][0]` = 3, `ob_matrix[0][0]` = 19, `oc_matrix[3][3]` = 50. `ostart` pulses once, one cycle after beat 50.
- Same job with `ivalid` toggled every other cycle → identical arrays. `ostart` follows the last accepted beat by one cycle.
- `ilast` on beat 20 → `oerr` pulse, no `ostart`, FSM in IDLE. The next 50-beat job completes normally.
- 50 beats with no `ilast` → `oerr` pulse on beat 50, no `ostart`.
- After `ostart`: `oready` = 0 and arrays are held unchanged for 100 cycles with `ivalid` = 1. `igemm_done` pulse → `obusy` falls next cycle and `oready` = 1.
- `irst` asserted at beat 30 → `oready` = 1, arrays = 0, `cnt` = 0 while reset is asserted. A full job after reset release completes normally.
